// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// The upstream side uses the master modport and the transmitter uses the slave modport.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one bit per CLK, LSB first, frame = start, data, optional parity, stop.
// Frame options are latched at accept, and TX_OUT/Busy come straight from flops.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  tx_bus
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  parity_bit;
  logic [CntW-1:0]       bit_cnt_inc;

  // New frames are only taken while idle or on the stop bit, which allows gapless streaming.
  assign accept      = tx_bus.Data_Valid && ((state_q == StIdle) || (state_q == StStop));
  assign parity_bit  = par_typ_q ? ~(^data_q) : (^data_q);
  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      StStart: begin
        state_d   = StData;
        bit_cnt_d = '0;
        tx_d      = data_q[0];
      end
      StData: begin
        if (bit_cnt_q == LastBit) begin
          bit_cnt_d = '0;
          if (par_en_q) begin
            state_d = StParity;
            tx_d    = parity_bit;
          end else begin
            state_d = StStop;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_inc;
          tx_d      = data_q[bit_cnt_inc];
        end
      end
      StParity: begin
        state_d = StStop;
        tx_d    = 1'b1;
      end
      StStop: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Accept overrides the idle/stop defaults above.
    if (accept) begin
      state_d   = StStart;
      data_d    = tx_bus.P_DATA;
      par_en_d  = tx_bus.PAR_EN;
      par_typ_d = tx_bus.PAR_TYP;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      data_q    <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_bus.TX_OUT = tx_q;
  assign tx_bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: the driver queues the expected line bits of each accepted frame,
// and a negedge monitor compares TX_OUT/Busy every cycle against the queue or the idle state.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam time HalfPeriod = 4340ns;

  logic CLK;
  logic RST;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .tx_bus (bus)
  );

  initial CLK = 1'b0;
  always #(HalfPeriod) CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  bit   mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptyp;
    logic       par;  // hand-computed parity bit
  } vec_t;

  vec_t vecs[6] = '{
    '{8'b1011_0010, 1'b1, 1'b0, 1'b0},
    '{8'b1011_0010, 1'b1, 1'b1, 1'b1},
    '{8'b1010_0100, 1'b1, 1'b0, 1'b1},
    '{8'b1010_0100, 1'b1, 1'b1, 1'b0},
    '{8'h00,        1'b1, 1'b1, 1'b1},
    '{8'hFF,        1'b1, 1'b0, 1'b0}
  };

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] data, input logic pen, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
    if (pen) exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  // Caller is just after a rising edge; the request is accepted at the next one.
  task automatic send(input logic [7:0] data, input logic pen, input logic ptyp, input logic par);
    bus.P_DATA     = data;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.Data_Valid = 1'b0;
    push_frame(data, pen, par);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain: %0d bits left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        logic e;
        e = exp_q.pop_front();
        check("frame_bit", bus.TX_OUT, e);
        check("busy_in_frame", bus.Busy, 1'b1);
      end else begin
        check("idle_line", bus.TX_OUT, 1'b1);
        check("idle_busy", bus.Busy, 1'b0);
      end
    end
  end

  initial begin
    RST            = 1'b0;
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_tx", bus.TX_OUT, 1'b1);
    check("reset_busy", bus.Busy, 1'b0);
    RST    = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // No parity: expect 0,0,1,0,0,1,1,0,1,1
    send(8'b1011_0010, 1'b0, 1'b0, 1'b0);
    wait_drain("no_parity");

    foreach (vecs[k]) begin
      send(vecs[k].data, vecs[k].pen, vecs[k].ptyp, vecs[k].par);
      wait_drain("parity");
    end

    // Back-to-back: second request during the stop bit of the first (entered 10 edges in).
    send(8'b1011_0010, 1'b1, 1'b0, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    check("b2b_busy_at_stop", bus.Busy, 1'b1);
    send(8'b1010_0100, 1'b1, 1'b0, 1'b1);
    wait_drain("back_to_back");

    // Dropped request plus mid-frame option changes during data bit 2.
    send(8'b1011_0010, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    bus.P_DATA     = 8'hFF;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b1;
    bus.Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.Data_Valid = 1'b0;
    wait_drain("dropped_req");
    repeat (12) @(posedge CLK);
    #1;

    // Asynchronous reset while data bit 3 (a zero) is on the line.
    send(8'b1011_0010, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge CLK);
    #2;
    check("pre_reset_bit3", bus.TX_OUT, 1'b0);
    mon_en = 1'b0;
    RST    = 1'b0;
    #1;
    check("async_rst_tx", bus.TX_OUT, 1'b1);
    check("async_rst_busy", bus.Busy, 1'b0);
    exp_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    mon_en = 1'b1;
    repeat (6) @(posedge CLK);
    #1;

    // Line still works after the reset.
    send(8'b1010_0100, 1'b1, 1'b1, 1'b0);
    wait_drain("post_reset");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(HalfPeriod * 2 * 2000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that sits directly upstream of the UART receiver and drives its RX_IN line.
- Accepts one parallel byte per handshake and serialises it LSB first, one bit per CLK period, as a frame: start bit, data bits, optional parity bit, stop bit.
- CLK runs at the bit rate (115.2 kHz nominal, period 8680.55 ns), so the frame format matches what the receiver expects.
- All frame options are latched at accept, so a frame is never corrupted by upstream changes mid-transmission.

Parameters:
DATA_WIDTH  8  number of data bits per frame

Ports:
CLK  input  1  bit-rate clock, rising-edge active
RST  input  1  asynchronous, active-low reset
P_DATA  input  DATA_WIDTH  parallel data to transmit
Data_Valid  input  1  request to transmit P_DATA; sampled on CLK rising edge
PAR_EN  input  1  1 = parity bit inserted
PAR_TYP  input  1  0 = even, 1 = odd
TX_OUT  output  1  serial line, idles high
Busy  output  1  high while a frame is in flight

Behaviour:
- Reset (RST=0, async): state=IDLE, TX_OUT=1, Busy=0, data shift register=0, bit counter=0, latched PAR_EN/PAR_TYP=0. Takes effect immediately, including mid-frame; partial frame abandoned, line returns high.
- State machine states: IDLE, START, DATA, PARITY, STOP. All outputs are registered (no combinational path from inputs to TX_OUT/Busy).
- Accept condition: Data_Valid=1 at a rising edge while state is IDLE or STOP. On accept:
  - latch P_DATA, PAR_EN, PAR_TYP;
  - state<=START, TX_OUT<=0, Busy<=1 on that same edge.
- Data_Valid in START/DATA/PARITY: ignored, request dropped, no error flag. Upstream must wait for Busy=0, or issue during the stop-bit cycle for back-to-back frames.
- START: one cycle. Then DATA, TX_OUT<=data[0].
- DATA: DATA_WIDTH cycles, TX_OUT=data[i] for i=0..DATA_WIDTH-1 (LSB first). Bit counter wraps to 0 at the last bit.
- After DATA: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: one cycle.
  - even: TX_OUT = XOR of latched data (total count of ones including parity is even);
  - odd: TX_OUT = XNOR of latched data;
  - parity is computed from the latched byte, never the live P_DATA.
- STOP: one cycle, TX_OUT=1, Busy=1.
  - With accept in this cycle: START follows immediately, no idle gap.
  - Without accept: state<=IDLE, Busy<=0, TX_OUT stays 1.
- Frame length: 10 cycles without parity, 11 with parity (DATA_WIDTH=8).
- Mid-frame changes to P_DATA/PAR_EN/PAR_TYP have no effect on the current frame.
- Data_Valid held high continuously produces back-to-back frames, each resampling P_DATA at its accept edge.

Test Plan:
- Reset: assert RST=0 mid-frame (during DATA bit 3) -> TX_OUT=1 and Busy=0 within the same time step; after release with Data_Valid=0 the line stays 1.
- No parity: P_DATA=8'b1011_0010, PAR_EN=0, one-cycle Data_Valid pulse -> TX_OUT sequence 0,0,1,0,0,1,1,0,1,1 over 10 cycles; Busy high for exactly those 10 cycles.
- Even/odd parity: P_DATA=8'b1011_0010 -> parity bit 0 (even) / 1 (odd). P_DATA=8'b1010_0100 -> parity bit 1 (even) / 0 (odd). Each frame is 11 cycles, ending in stop=1.
- Back-to-back: Data_Valid high during the stop cycle of frame 1 (8'b1011_0010), then frame 2 (8'b1010_0100), even parity -> start bit of frame 2 directly follows stop bit of frame 1; Busy never drops between frames.
- Dropped request: Data_Valid pulse with P_DATA=8'hFF during DATA bit 2 of a frame -> current frame unchanged, no second frame sent, Busy falls after stop.
- Loopback: TX_OUT driven into the receiver with Prescale=8, 16, 32 -> receiver P_DATA equals sent byte, data_valid=1, Parity_Error=0, Stop_Error=0 for all parity configurations.
